// File: rtl/rca_seq_add_ctrl_pkg.sv
// Shared definitions for the sequential ripple-carry adder controller:
// FSM encodings, default geometry and the slice-index width helper.
package rca_seq_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_SLICE_W    = 5;
    localparam int DEF_NUM_SLICES = 4;

    // A single-slice build still needs a one-bit index register.
    function automatic int idx_width(input int num_slices);
        return (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/rca_seq_add_ctrl_if.sv
// Requester <-> controller bundle. Optional macro SUB_EN adds the sub
// request bit alongside the operands.
interface rca_seq_add_ctrl_if #(
    parameter int SLICE_W    = rca_seq_add_ctrl_pkg::DEF_SLICE_W,
    parameter int NUM_SLICES = rca_seq_add_ctrl_pkg::DEF_NUM_SLICES
);
    localparam int TOT_W = SLICE_W * NUM_SLICES;

    logic             start;
    logic [TOT_W-1:0] a;
    logic [TOT_W-1:0] b;
    logic             c_in;
`ifdef SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [TOT_W-1:0] s;
    logic             c_out;

`ifdef SUB_EN
    modport master (output start, a, b, c_in, sub, input busy, done, s, c_out);
    modport slave  (input start, a, b, c_in, sub, output busy, done, s, c_out);
`else
    modport master (output start, a, b, c_in, input busy, done, s, c_out);
    modport slave  (input start, a, b, c_in, output busy, done, s, c_out);
`endif

endinterface

// File: rtl/rca_seq_add_ctrl_slice.sv
// rca_slice: purely combinational SLICE_W-bit ripple-carry adder, the one
// piece of arithmetic the controller reuses every RUN cycle.
module rca_slice #(
    parameter int SLICE_W = 5
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c_in,
    output logic [SLICE_W-1:0] s,
    output logic               c_out
);

    logic [SLICE_W:0] carry;

    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
            assign s[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = carry[SLICE_W];

endmodule

// File: rtl/rca_seq_add_ctrl.sv
// Wide adder built from one reused rca_slice, LS slice first, carry held in
// a register between cycles. Macro SUB_EN enables a-b via the sub request bit.
module rca_seq_add_ctrl
    import rca_seq_add_ctrl_pkg::*;
#(
    parameter int SLICE_W    = DEF_SLICE_W,
    parameter int NUM_SLICES = DEF_NUM_SLICES
) (
    input  logic                clk,
    input  logic                rst_n,
    rca_seq_add_ctrl_if.slave   bus_if
);

    localparam int TOT_W = SLICE_W * NUM_SLICES;
    localparam int IDX_W = idx_width(NUM_SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_e             state_q, state_d;
    logic [TOT_W-1:0]   op_a_q, op_a_d;
    logic [TOT_W-1:0]   op_b_q, op_b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TOT_W-1:0]   s_q, s_d;
    logic               c_out_q, c_out_d;

    logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
    logic               slice_c;

    assign slice_a = op_a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign slice_b = op_b_q[int'(idx_q)*SLICE_W +: SLICE_W];

    rca_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_c)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        c_out_d = c_out_q;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.start) begin
                    op_a_d  = bus_if.a;
                    idx_d   = '0;
                    s_d     = '0;
`ifdef SUB_EN
                    // Two's-complement subtract: invert b and force carry-in.
                    op_b_d  = bus_if.sub ? ~bus_if.b : bus_if.b;
                    carry_d = bus_if.sub ? 1'b1 : bus_if.c_in;
`else
                    op_b_d  = bus_if.b;
                    carry_d = bus_if.c_in;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d[int'(idx_q)*SLICE_W +: SLICE_W] = slice_s;
                carry_d = slice_c;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    c_out_d = slice_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
        end
    end

    // busy/done decode only the state register, so no input reaches an output.
    assign bus_if.busy  = (state_q != ST_IDLE);
    assign bus_if.done  = (state_q == ST_DONE);
    assign bus_if.s     = s_q;
    assign bus_if.c_out = c_out_q;

endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Randomized + directed bench for rca_seq_add_ctrl against a cycle-count /
// arithmetic model; one line is printed per completed transaction.
module tb_rca_seq_add_ctrl;

    localparam int SLICE_W    = 5;
    localparam int NUM_SLICES = 4;
    localparam int TOT_W      = SLICE_W * NUM_SLICES;
    localparam int LAT        = NUM_SLICES + 1;
    localparam int INTERVAL   = NUM_SLICES + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rca_seq_add_ctrl_if #(.SLICE_W(SLICE_W), .NUM_SLICES(NUM_SLICES)) bus ();

    rca_seq_add_ctrl #(
        .SLICE_W    (SLICE_W),
        .NUM_SLICES (NUM_SLICES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: m_cnt = cycles of busy left; result is plain wide arithmetic.
    int               m_cnt = 0;
    logic [TOT_W-1:0] m_s = '0;
    logic             m_c = 1'b0;
    logic [TOT_W-1:0] p_s, p_a, p_b;
    logic             p_c, p_cin, p_sub;

    always @(posedge clk or negedge rst_n) begin
        logic [TOT_W:0] r;
        logic           sb;
        if (!rst_n) begin
            m_cnt = 0;
            m_s   = '0;
            m_c   = 1'b0;
        end else begin
            cyc++;
            if (m_cnt == 0 && bus.start === 1'b1) begin
`ifdef SUB_EN
                sb = bus.sub;
`else
                sb = 1'b0;
`endif
                if (sb) r = {1'b0, bus.a} + {1'b0, ~bus.b} + (TOT_W+1)'(1);
                else    r = {1'b0, bus.a} + {1'b0, bus.b} + (TOT_W+1)'(bus.c_in);
                p_s = r[TOT_W-1:0];
                p_c = r[TOT_W];
                p_a = bus.a; p_b = bus.b; p_cin = bus.c_in; p_sub = sb;
                m_cnt = LAT;
                m_s   = '0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 1) begin
                    m_s = p_s;
                    m_c = p_c;
                    $display("TXN cyc=%0d a=0x%05h b=0x%05h cin=%0d sub=%0d -> s=0x%05h c_out=%0d",
                             cyc, p_a, p_b, p_cin, p_sub, p_s, p_c);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_cnt != 0));
        chk("done", 32'(bus.done), 32'(m_cnt == 1));
        chk("c_out", 32'(bus.c_out), 32'(m_c));
        if (m_cnt <= 1) chk("s", 32'(bus.s), 32'(m_s));
    end

    task automatic drive(input logic st, input logic [TOT_W-1:0] ta, input logic [TOT_W-1:0] tb_,
                         input logic tc, input logic tsub);
        bus.start = st;
        bus.a     = ta;
        bus.b     = tb_;
        bus.c_in  = tc;
`ifdef SUB_EN
        bus.sub   = tsub;
`else
        if (tsub) $display("note: sub ignored in add-only build");
`endif
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and pin latency and result to literals.
    task automatic do_op(input string nm, input logic [TOT_W-1:0] ta, input logic [TOT_W-1:0] tb_,
                         input logic tc, input logic tsub,
                         input logic [TOT_W-1:0] es, input logic ec);
        int  n;
        bit  seen;
        drive(1'b1, ta, tb_, tc, tsub);
        next_cycle();
        drive(1'b0, ta, tb_, tc, 1'b0);
        seen = 0;
        n    = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 20 cycles", nm);
        end else begin
            chk({nm, "_latency"}, 32'(n), 32'(LAT));
            chk({nm, "_s"}, 32'(bus.s), 32'(es));
            chk({nm, "_c_out"}, 32'(bus.c_out), 32'(ec));
        end
        next_cycle();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int last_done;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_s", 32'(bus.s), 32'd0);
        chk("rst_c_out", 32'(bus.c_out), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        do_op("basic", 20'h00015, 20'h0000A, 1'b0, 1'b0, 20'h0001F, 1'b0);
        do_op("chain", 20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1);

        // Abort while idx==2: outputs must drop immediately, no done.
        drive(1'b1, 20'h12345, 20'h0F0F0, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 20'h0, 20'h0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk("abort_s", 32'(bus.s), 32'd0);
        chk("abort_c_out", 32'(bus.c_out), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        do_op("cin", 20'h00000, 20'h00000, 1'b1, 1'b0, 20'h00001, 1'b0);
        do_op("post_abort", 20'h12345, 20'h0F0F0, 1'b1, 1'b0, 20'h21436, 1'b0);

        // Second start while busy must be ignored.
        drive(1'b1, 20'h00100, 20'h00023, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 20'h0, 20'h0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 20'hABCDE, 20'h11111, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 20'h0, 20'h0, 1'b0, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dones++;
                chk("lockout_s", 32'(bus.s), 32'h00123);
            end
        end
        chk("lockout_dones", 32'(dones), 32'd1);
        next_cycle();

`ifdef SUB_EN
        do_op("sub_pos", 20'h00005, 20'h00003, 1'b0, 1'b1, 20'h00002, 1'b1);
        do_op("sub_neg", 20'h00003, 20'h00005, 1'b0, 1'b1, 20'hFFFFE, 1'b0);
`endif

        // Start held high: dones must be exactly INTERVAL cycles apart.
        last_done = -1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 20'($urandom), 20'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (last_done >= 0) chk("b2b_spacing", 32'(cyc - last_done), 32'(INTERVAL));
                last_done = cyc;
                dones++;
            end
            next_cycle();
        end
        chk("b2b_count_ok", 32'(dones >= 5), 32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (8) next_cycle();

        // Random traffic, including start toggling while busy.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 2) == 0), 20'($urandom), 20'($urandom), 1'($urandom),
                  1'($urandom_range(0, 1)));
            next_cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (10) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
